// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: shared types and constants for the multi-channel clock/tick generator.
//   CNT_W       width of period / high-time / phase fields
//   DEF_PERIOD  channel period after reset (Clk cycles)
//   DEF_HIGH    channel high time after reset (Clk cycles)
//   cfg_t       configuration payload {period, high[, phase]}
//   eff_period  clamps a programmed period to the minimum usable value of 2
// Optional feature macro: CLKGEN_PHASE_EN adds the phase field to cfg_t.
package clk_gen_pkg;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned DEF_PERIOD = 13;
  localparam int unsigned DEF_HIGH   = 6;

`ifdef CLKGEN_PHASE_EN
  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] phase;
  } cfg_t;
`else
  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } cfg_t;
`endif

  // A period below 2 cannot hold both a high and a low cycle; treat it as 2.
  function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] period);
    return (period < CNT_W'(2)) ? CNT_W'(2) : period;
  endfunction

endpackage

// File: rtl/clk_gen_ch.sv
// clk_gen_ch: one divider channel.
//   clk_i     system clock
//   rst_i     synchronous active-high reset
//   en_i      run enable
//   cfg_we_i  accepted configuration strobe (only asserted while not pending)
//   cfg_i     configuration payload written to the shadow register
//   pend_o    shadow holds a config not yet copied to the active register
//   div_o     registered divided clock level
//   tick_o    registered pulse in the last cycle of each period
// Optional feature macro: CLKGEN_PHASE_EN (enable edge starts the count at the phase).
module clk_gen_ch #(
  parameter int unsigned DEF_PERIOD = clk_gen_pkg::DEF_PERIOD,
  parameter int unsigned DEF_HIGH   = clk_gen_pkg::DEF_HIGH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              cfg_we_i,
  input  clk_gen_pkg::cfg_t cfg_i,
  output logic              pend_o,
  output logic              div_o,
  output logic              tick_o
);
  import clk_gen_pkg::*;

`ifdef CLKGEN_PHASE_EN
  localparam cfg_t CFG_RST = '{period: CNT_W'(DEF_PERIOD),
                               high:   CNT_W'(DEF_HIGH),
                               phase:  '0};
`else
  localparam cfg_t CFG_RST = '{period: CNT_W'(DEF_PERIOD),
                               high:   CNT_W'(DEF_HIGH)};
`endif

  cfg_t             act_q, act_d;
  cfg_t             shd_q, shd_d;
  cfg_t             cur;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] p_old, p_cur, start;
  logic             pend_q, pend_d;
  logic             div_q, div_d;
  logic             tick_q, tick_d;
  logic             en_q;
  logic             wrap, apply;

  // Next-state: counter, config apply at period boundary, registered outputs.
  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    cnt_d  = '0;
    div_d  = 1'b0;
    tick_d = 1'b0;
    start  = '0;

    p_old = eff_period(act_q.period);
    wrap  = en_i & en_q & (cnt_q >= p_old - CNT_W'(1));
    // Safe apply points: running wrap, enable edge, or while disabled.
    apply = pend_q & (~en_i | ~en_q | wrap);
    cur   = apply ? shd_q : act_q;
    p_cur = eff_period(cur.period);

`ifdef CLKGEN_PHASE_EN
    start = (cur.phase >= p_cur - CNT_W'(1)) ? (p_cur - CNT_W'(1)) : cur.phase;
`endif

    if (apply) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
    if (cfg_we_i) begin
      shd_d  = cfg_i;
      pend_d = 1'b1;
    end

    if (en_i) begin
      if (!en_q) begin
        cnt_d = start;
      end else if (wrap) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      div_d  = (cnt_d < cur.high);
      tick_d = (cnt_d == p_cur - CNT_W'(1));
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_q  <= CFG_RST;
      shd_q  <= CFG_RST;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      div_q  <= 1'b0;
      tick_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      div_q  <= div_d;
      tick_q <= tick_d;
      en_q   <= en_i;
    end
  end

  assign pend_o = pend_q;
  assign div_o  = div_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clk_gen_multi.sv
// clk_gen_multi: NUM_CH independent programmable clock/tick dividers of Clk.
//   Clk         system clock (rising edge)
//   Rst         synchronous active-high reset
//   Ch_en       per-channel run enable
//   Cfg_valid   configuration request
//   Cfg_ready   combinational: target channel has no pending config
//   Cfg_ch      target channel
//   Cfg_period  new period (values below 2 act as 2)
//   Cfg_high    new high time (0: always low, >= period: always high)
//   Cfg_phase   start count on enable edge (only with CLKGEN_PHASE_EN)
//   Div_clk     registered divided clock per channel
//   Tick        one-cycle pulse in the last cycle of each period
//   Pending     accepted config awaiting a period boundary
// Optional feature macro: CLKGEN_PHASE_EN.
// CNT_W must equal clk_gen_pkg::CNT_W, which sizes the config payload.
module clk_gen_multi #(
  parameter  int unsigned NUM_CH     = 4,
  parameter  int unsigned CNT_W      = clk_gen_pkg::CNT_W,
  parameter  int unsigned DEF_PERIOD = clk_gen_pkg::DEF_PERIOD,
  parameter  int unsigned DEF_HIGH   = clk_gen_pkg::DEF_HIGH,
  localparam int unsigned ID_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NUM_CH-1:0] Ch_en,
  input  logic              Cfg_valid,
  output logic              Cfg_ready,
  input  logic [ID_W-1:0]   Cfg_ch,
  input  logic [CNT_W-1:0]  Cfg_period,
  input  logic [CNT_W-1:0]  Cfg_high,
`ifdef CLKGEN_PHASE_EN
  input  logic [CNT_W-1:0]  Cfg_phase,
`endif
  output logic [NUM_CH-1:0] Div_clk,
  output logic [NUM_CH-1:0] Tick,
  output logic [NUM_CH-1:0] Pending
);
  import clk_gen_pkg::*;

  logic [NUM_CH-1:0] pend;
  logic              accept;
  cfg_t              cfg;

  // Channels outside NUM_CH never accept a config.
  assign Cfg_ready = (32'(Cfg_ch) < NUM_CH) ? ~pend[Cfg_ch] : 1'b0;
  assign accept    = Cfg_valid & Cfg_ready;
  assign Pending   = pend;

  // Pack the request into the shared payload.
  always_comb begin
    cfg        = '0;
    cfg.period = Cfg_period;
    cfg.high   = Cfg_high;
`ifdef CLKGEN_PHASE_EN
    cfg.phase  = Cfg_phase;
`endif
  end

  // One divider per channel; only the addressed channel sees the write strobe.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_gen_ch #(
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH)
    ) u_ch (
      .clk_i    (Clk),
      .rst_i    (Rst),
      .en_i     (Ch_en[g]),
      .cfg_we_i (accept & (Cfg_ch == ID_W'(g))),
      .cfg_i    (cfg),
      .pend_o   (pend[g]),
      .div_o    (Div_clk[g]),
      .tick_o   (Tick[g])
    );
  end

endmodule

// File: tb/tb_clk_gen_multi.sv
// tb_clk_gen_multi: directed self-checking bench for clk_gen_multi.
// Optional feature macro: CLKGEN_PHASE_EN enables the phase-start checks.
module tb_clk_gen_multi;

  logic        Clk;
  logic        Rst;
  logic [3:0]  Ch_en;
  logic        Cfg_valid;
  logic        Cfg_ready;
  logic [1:0]  Cfg_ch;
  logic [15:0] Cfg_period;
  logic [15:0] Cfg_high;
`ifdef CLKGEN_PHASE_EN
  logic [15:0] Cfg_phase;
`endif
  logic [3:0]  Div_clk;
  logic [3:0]  Tick;
  logic [3:0]  Pending;

  int errs   = 0;
  int checks = 0;

  // Expected per-cycle patterns for the mid-period reconfiguration of channel 1.
  logic [0:13] e2_div  = 14'b11110000100001;
  logic [0:13] e2_tick = 14'b00000001000010;
  logic [0:13] e2_pend = 14'b00011111000000;
`ifdef CLKGEN_PHASE_EN
  logic [0:12] e6_div  = 13'b0001111100000;
  logic [0:12] e6_tick = 13'b0010000000001;
`endif

  clk_gen_multi u_dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Ch_en      (Ch_en),
    .Cfg_valid  (Cfg_valid),
    .Cfg_ready  (Cfg_ready),
    .Cfg_ch     (Cfg_ch),
    .Cfg_period (Cfg_period),
    .Cfg_high   (Cfg_high),
`ifdef CLKGEN_PHASE_EN
    .Cfg_phase  (Cfg_phase),
`endif
    .Div_clk    (Div_clk),
    .Tick       (Tick),
    .Pending    (Pending)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic cfg_set(input logic [1:0] ch, input logic [15:0] per, input logic [15:0] hi);
    Cfg_ch     = ch;
    Cfg_period = per;
    Cfg_high   = hi;
    Cfg_valid  = 1'b1;
  endtask

  initial begin
    Rst        = 1'b1;
    Ch_en      = 4'b0000;
    Cfg_valid  = 1'b0;
    Cfg_ch     = 2'd0;
    Cfg_period = 16'd0;
    Cfg_high   = 16'd0;
`ifdef CLKGEN_PHASE_EN
    Cfg_phase  = 16'd0;
`endif
    step();
    step();
    check("rst div", 32'(Div_clk), 32'h0);
    check("rst tick", 32'(Tick), 32'h0);
    check("rst pend", 32'(Pending), 32'h0);
    check("rst ready", 32'(Cfg_ready), 32'h1);
    Rst = 1'b0;
    step();

    // Defaults on channel 0: period 13, 6 high, tick on cnt 12.
    Ch_en = 4'b0001;
    for (int i = 0; i < 26; i++) begin
      step();
      check($sformatf("t1 div i=%0d", i), 32'(Div_clk[0]), 32'((i % 13) < 6));
      check($sformatf("t1 tick i=%0d", i), 32'(Tick[0]), 32'((i % 13) == 12));
    end
    check("t1 others idle", 32'(Div_clk[3:1]), 32'h0);
    step();
    step();
    check("t1 div before drop", 32'(Div_clk[0]), 32'h1);
    Ch_en = 4'b0000;
    step();
    check("t1 drop div", 32'(Div_clk[0]), 32'h0);
    check("t1 drop tick", 32'(Tick[0]), 32'h0);

    // Channel 1 {8,4} configured while disabled: applies one cycle later.
    cfg_set(2'd1, 16'd8, 16'd4);
    #1;
    check("t2 ready idle", 32'(Cfg_ready), 32'h1);
    step();
    Cfg_valid = 1'b0;
    check("t2 pend set", 32'(Pending), 32'h2);
    step();
    check("t2 pend applied", 32'(Pending), 32'h0);

    // Reconfigure ch1 to {5,1} mid-period; blocked second write; ch2 write accepted.
    Ch_en = 4'b0010;
    for (int j = 0; j < 14; j++) begin
      step();
      check($sformatf("t2 div j=%0d", j), 32'(Div_clk[1]), 32'(e2_div[j]));
      check($sformatf("t2 tick j=%0d", j), 32'(Tick[1]), 32'(e2_tick[j]));
      check($sformatf("t2 pend j=%0d", j), 32'(Pending[1]), 32'(e2_pend[j]));
      if (j == 2) begin
        cfg_set(2'd1, 16'd5, 16'd1);
        #1;
        check("t2 ready before accept", 32'(Cfg_ready), 32'h1);
      end
      if (j == 3) begin
        Cfg_valid = 1'b0;
        #1;
        check("t2 ready while pending", 32'(Cfg_ready), 32'h0);
      end
      if (j == 4) begin
        cfg_set(2'd1, 16'd3, 16'd3);
        #1;
        check("t4 ready same ch", 32'(Cfg_ready), 32'h0);
      end
      if (j == 5) begin
        check("t4 ch2 not pending", 32'(Pending[2]), 32'h0);
        cfg_set(2'd2, 16'd6, 16'd9);
        #1;
        check("t4 ready other ch", 32'(Cfg_ready), 32'h1);
      end
      if (j == 6) begin
        check("t4 ch2 accepted", 32'(Pending[2]), 32'h1);
        Cfg_valid = 1'b0;
      end
      if (j == 7) check("t4 ch2 applied", 32'(Pending[2]), 32'h0);
    end

    // Ch3 {1,0} -> period 2 always low; ch2 {6,9} -> period 6 always high.
    Ch_en = 4'b0000;
    cfg_set(2'd3, 16'd1, 16'd0);
    step();
    Cfg_valid = 1'b0;
    step();
    Ch_en = 4'b1100;
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("t3 ch2 div k=%0d", k), 32'(Div_clk[2]), 32'h1);
      check($sformatf("t3 ch2 tick k=%0d", k), 32'(Tick[2]), 32'((k % 6) == 5));
      check($sformatf("t3 ch3 div k=%0d", k), 32'(Div_clk[3]), 32'h0);
      check($sformatf("t3 ch3 tick k=%0d", k), 32'(Tick[3]), 32'((k % 2) == 1));
      check($sformatf("t3 ch1 off k=%0d", k), 32'(Div_clk[1]), 32'h0);
    end

    // Reset with a pending config on ch2: everything back to defaults.
    cfg_set(2'd2, 16'd4, 16'd2);
    #1;
    check("t5 ready", 32'(Cfg_ready), 32'h1);
    step();
    Cfg_valid = 1'b0;
    check("t5 pend before rst", 32'(Pending), 32'h4);
    Rst = 1'b1;
    step();
    check("t5 rst div", 32'(Div_clk), 32'h0);
    check("t5 rst tick", 32'(Tick), 32'h0);
    check("t5 rst pend", 32'(Pending), 32'h0);
    Rst   = 1'b0;
    Ch_en = 4'b0100;
    for (int i = 0; i < 14; i++) begin
      step();
      check($sformatf("t5 div i=%0d", i), 32'(Div_clk[2]), 32'((i % 13) < 6));
      check($sformatf("t5 tick i=%0d", i), 32'(Tick[2]), 32'((i % 13) == 12));
      check($sformatf("t5 pend i=%0d", i), 32'(Pending), 32'h0);
    end

`ifdef CLKGEN_PHASE_EN
    // Phase 7 on {10,5}: 3 low cycles, then normal 5/5.
    Ch_en = 4'b0000;
    step();
    Cfg_phase = 16'd7;
    cfg_set(2'd0, 16'd10, 16'd5);
    step();
    Cfg_valid = 1'b0;
    step();
    Ch_en = 4'b0001;
    for (int e = 0; e < 13; e++) begin
      step();
      check($sformatf("t6 div e=%0d", e), 32'(Div_clk[0]), 32'(e6_div[e]));
      check($sformatf("t6 tick e=%0d", e), 32'(Tick[0]), 32'(e6_tick[e]));
    end
    // Phase 12 clamps to 9: immediate last cycle.
    Ch_en = 4'b0000;
    step();
    Cfg_phase = 16'd12;
    cfg_set(2'd0, 16'd10, 16'd5);
    step();
    Cfg_valid = 1'b0;
    step();
    Ch_en = 4'b0001;
    step();
    check("t6 clamp div0", 32'(Div_clk[0]), 32'h0);
    check("t6 clamp tick0", 32'(Tick[0]), 32'h1);
    step();
    check("t6 clamp div1", 32'(Div_clk[0]), 32'h1);
    check("t6 clamp tick1", 32'(Tick[0]), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/clk_gen_multi.md
Name: clk_gen_multi

Overview:
Synthesizable, parametrised multi-channel clock/tick generator for the RV32I platform. Each channel divides the system clock `Clk` by a programmable period with a programmable high time. Each channel produces a divided clock level and a one-cycle end-of-period tick. It is used to time peripherals (timers, UART baud, debouncers) and replaces fixed-period behavioural clock sources. Per-channel period and high time are reconfigured at runtime through a valid/ready port and take effect glitch-free at a period boundary.

Parameters:
NUM_CH, 4, number of independent channels
CNT_W, 16, width of period/high-time counters
DEF_PERIOD, 13, per-channel period after reset (in Clk cycles)
DEF_HIGH, 6, per-channel high time after reset (in Clk cycles)
ID_W, $clog2(NUM_CH) (min 1), derived; channel-select width

Ports:
Clk  in  1  system clock; all logic on its rising edge
Rst  in  1  reset: synchronous, active-high
Ch_en  in  NUM_CH  per-channel run enable
Cfg_valid  in  1  configuration request
Cfg_ready  out  1  configuration accepted this cycle when high together with Cfg_valid
Cfg_ch  in  ID_W  target channel
Cfg_period  in  CNT_W  new period
Cfg_high  in  CNT_W  new high time
Div_clk  out  NUM_CH  registered divided clock level per channel
Tick  out  NUM_CH  one-cycle pulse in the last cycle of each period
Pending  out  NUM_CH  channel holds an accepted config that is not yet applied

Behaviour:
- Reset (Rst high at a Clk edge):
  - All counters are 0.
  - Div_clk = 0, Tick = 0, Pending = 0.
  - Active and shadow configs are {DEF_PERIOD, DEF_HIGH}.
  - Reset dominates every other input, including mid-period or with a config pending.
- Effective period:
  - p = max(period, 2).
  - high == 0 gives Div_clk constantly 0.
  - high >= p gives Div_clk constantly 1.
  - Tick still pulses once per period in both cases.
- Counter, per enabled channel:
  - cnt runs 0..p-1 and wraps to 0.
  - Div_clk and Tick are registered from the next-state count:
    - Div_clk <= (cnt_next < high).
    - Tick <= (cnt_next == p-1).
  - Output period = exactly p Clk cycles; high phase = high cycles.
- Enable:
  - Ch_en sampled low: cnt held 0, Div_clk = 0, Tick = 0.
  - First edge with Ch_en sampled high: cnt_next = 0, so Div_clk = 1 (if high > 0) on that edge. Latency 1 cycle.
  - Ch_en dropped mid-period: outputs go low on the next edge; no completion of the current period.
- Config handshake:
  - Cfg_ready = ~Pending[Cfg_ch]. It is combinational on Cfg_ch and independent of Cfg_valid.
  - Accept when Cfg_valid & Cfg_ready: the shadow is written and Pending[ch] is set next cycle.
- Config apply:
  - Enabled channel: the shadow is copied to active at the edge where cnt wraps p-1 -> 0. The new period governs cnt from that edge on. Pending clears on the same edge.
  - Acceptance on the exact wrap edge of that channel does not apply at that wrap; it applies at the following wrap.
  - Disabled channel: the config applies one cycle after acceptance.
  - The active config never changes mid-period, so Div_clk is glitch-free.
- Concurrency: only one channel can be configured per cycle. Other channels are unaffected by configuration traffic.

Optional Feature:
Macro CLKGEN_PHASE_EN.
- Defined:
  - Adds input Cfg_phase [CNT_W] and a per-channel phase register, written on config accept.
  - On the enable edge (Ch_en sampled 0 -> 1), cnt_next = min(phase, p-1) instead of 0.
  - Phase does not affect wraps during running operation.
  - Phase resets to 0.
- Undefined: the port and register are absent, and cnt always starts at 0.

Decomposition:
- Package clk_gen_pkg:
  - Default CNT_W.
  - The cfg struct {period, high[, phase]}.
  - Function eff_period(), which clamps the period to >= 2.
  - Constants DEF_PERIOD and DEF_HIGH.
- Sub-module clk_gen_ch: one channel (counter, active/shadow config, pending flag, output regs).
- Top clk_gen_multi generates NUM_CH instances, decodes Cfg_ch and muxes Cfg_ready.

Test Plan:
1. After reset, Ch_en[0]=1, defaults -> Div_clk[0] period 13 cycles, 6 high / 7 low. Tick[0] once per 13 cycles, coincident with the last low cycle.
2. Channel 1 running {8,4}; accept {5,1} mid-period at cnt=2 -> Pending[1]=1 and Cfg_ready=0 for ch1 until the wrap. The 8-cycle period completes, then a period of 5 with 1 high follows. No short or long pulse.
3. Cfg {1,0} and {6,9} -> effective period 2 with Div_clk constantly 0 (Tick every 2 cycles), and period 6 with Div_clk constantly 1 (Tick every 6 cycles).
4. Second config to the same channel while Pending -> Cfg_ready=0, shadow unchanged. A config to another channel in the same cycle (Cfg_ch changed) is accepted.
5. Rst asserted mid-period with Pending[2]=1 -> next edge: all outputs 0, Pending 0, configs back to {13,6}. The pending config is discarded.
6. CLKGEN_PHASE_EN: ch0 {10,5} with phase 7, Ch_en 0 -> 1 -> first period has 3 low cycles then a normal 5/5. Phase 12 clamps to start cnt 9.
